dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter MEM_SIZE, default 1024: number of words.
REQ-003 Parameter ADDR_WIDTH, default 10: address width; 2^ADDR_WIDTH >= MEM_SIZE.
REQ-004 Parameter OUT_REG, default 0: 1 adds one output pipeline stage.
REQ-005 Parameter WR_FIRST, default 0: read-during-write policy (0 = old data, 1 = new data).
REQ-006 The block has one clock; reset is synchronous and active-high.
REQ-007 DPRAM_Clk  in  1  sole clock, all state updates on rising edge.
REQ-008 DPRAM_Reset_InHigh  in  1  synchronous, active-high reset.
REQ-009 DPRAM_Wr_En  in  1  write request.
REQ-010 DPRAM_Wr_Be  in  DATA_WIDTH/8  byte-lane write enables; bit i covers Wr_Data[8i+7:8i].
REQ-011 DPRAM_Wr_Address  in  ADDR_WIDTH  write address.
REQ-012 DPRAM_Wr_Data  in  DATA_WIDTH  write data.
REQ-013 DPRAM_Rd_En  in  1  read request.
REQ-014 DPRAM_Rd_Address  in  ADDR_WIDTH  read address.
REQ-015 DPRAM_Oe  in  1  output enable; combinational gating of Rd_Data only.
REQ-016 DPRAM_Clear  in  1  single-cycle request to zero the whole array.
REQ-017 DPRAM_Rd_Data  out  DATA_WIDTH  read data.
REQ-018 DPRAM_Rd_Valid  out  1  one-cycle pulse per accepted read.
REQ-019 DPRAM_Busy  out  1  high while clear sequence runs.

Function
REQ-020 Write accepted when Wr_En=1, Busy=0, Wr_Address<MEM_SIZE: only lanes with Be=1 updated at that edge; other lanes retain value.
REQ-021 Write with Wr_Address>=MEM_SIZE or Be=0 changes no memory.
REQ-022 Read accepted when Rd_En=1, Busy=0: word captured into read register at that edge; Rd_Address>=MEM_SIZE captures 0.
REQ-023 Latency: Rd_Valid and new Rd_Data appear 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1); back-to-back reads give one Valid pulse per read, full throughput.
REQ-024 Rd_Data holds last read value until the next accepted read reaches the output.
REQ-025 Same-address collision (write and read accepted same edge): WR_FIRST=0 returns pre-write word; WR_FIRST=1 returns byte-merged new word (written lanes new, others old).
REQ-026 Rd_Data = Oe ? output register : 0; Rd_Valid not gated by Oe.
REQ-027 FSM states IDLE, CLEAR; IDLE->CLEAR when Clear=1 in IDLE; counter starts 0.
REQ-028 In CLEAR: one word zeroed per cycle at counter address, counter +1; after writing MEM_SIZE-1 -> IDLE; Busy=1 for exactly MEM_SIZE cycles, starting the cycle after Clear sampled.
REQ-029 Clear while Busy=1 ignored; no restart.
REQ-030 Clear and accepted write same edge in IDLE: write performed, clear then zeroes it.
REQ-031 Reads/writes requested while Busy=1 dropped silently; no Rd_Valid generated.
REQ-032 Reads accepted before Busy rose complete normally through the pipeline.

Reset
REQ-033 Reset has priority over all inputs: FSM=IDLE, counter=0, Busy=0, Rd_Valid=0, read/output registers=0 (Rd_Data=0), pipeline flushed.
REQ-034 Memory contents not altered by reset; reset mid-clear aborts, leaving partially zeroed array.
REQ-035 Read in flight when reset asserts produces no Rd_Valid.

Verification (DATA_WIDTH=32, MEM_SIZE=16, ADDR_WIDTH=4)
REQ-036 Write 0xAABBCCDD @3 Be=1111, then Be=0101 data 0x11223344 @3, read @3 -> Rd_Data=0xAA22CC44, Valid 1 cycle later (OUT_REG=0), 2 (OUT_REG=1).
REQ-037 Collision @5 holding 0x0, write 0xFFFFFFFF Be=1111 + read same edge -> 0x00000000 (WR_FIRST=0), 0xFFFFFFFF (WR_FIRST=1).
REQ-038 Fill all 16 words, pulse Clear -> Busy high exactly 16 cycles, Wr_En/Rd_En during Busy ignored, then reads of 0..15 all return 0.
REQ-039 Reset at 8th Busy cycle -> Busy=0 next cycle; words 0..6 read 0, words 8..15 keep prior data.
REQ-040 Read @2 (0x12345678) with Oe=0 -> Rd_Data=0, Valid pulses; raise Oe -> 0x12345678 same cycle without new read.

Source files
------------

// File: rtl/dual_port_ram.sv
// dual_port_ram: one write port and one read port on a shared clock, with
// byte-lane write enables, an optional output pipeline stage, a selectable
// read-during-write policy and a one-word-per-cycle background clear.
//
// Ports
//   DPRAM_Clk           clock, all state on rising edge
//   DPRAM_Reset_InHigh  synchronous active-high reset (memory array untouched)
//   DPRAM_Wr_En/Be/Address/Data   write request, Be bit i covers byte i
//   DPRAM_Rd_En/Address           read request
//   DPRAM_Oe            combinational gate on Rd_Data only
//   DPRAM_Clear         request to zero the whole array
//   DPRAM_Rd_Data       read data (held until the next read reaches the output)
//   DPRAM_Rd_Valid      one-cycle pulse per accepted read
//   DPRAM_Busy          high while the clear sweep runs
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int WR_FIRST   = 0
) (
  input  logic                    DPRAM_Clk,
  input  logic                    DPRAM_Reset_InHigh,
  input  logic                    DPRAM_Wr_En,
  input  logic [DATA_WIDTH/8-1:0] DPRAM_Wr_Be,
  input  logic [ADDR_WIDTH-1:0]   DPRAM_Wr_Address,
  input  logic [DATA_WIDTH-1:0]   DPRAM_Wr_Data,
  input  logic                    DPRAM_Rd_En,
  input  logic [ADDR_WIDTH-1:0]   DPRAM_Rd_Address,
  input  logic                    DPRAM_Oe,
  input  logic                    DPRAM_Clear,
  output logic [DATA_WIDTH-1:0]   DPRAM_Rd_Data,
  output logic                    DPRAM_Rd_Valid,
  output logic                    DPRAM_Busy
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic                    vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic                    out_vld_q, out_vld_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

  logic                    wr_ok, rd_ok, rd_in_range;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NB-1:0]           mem_be;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign wr_ok       = DPRAM_Wr_En && !busy_q && (32'(DPRAM_Wr_Address) < MEM_SIZE);
  assign rd_ok       = DPRAM_Rd_En && !busy_q;
  assign rd_in_range = 32'(DPRAM_Rd_Address) < MEM_SIZE;

  // Clear FSM and the single memory write port. While clearing, the sweep
  // owns the write port; user traffic is dropped because busy_q is high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_addr  = DPRAM_Wr_Address;
    mem_wdata = DPRAM_Wr_Data;
    mem_be    = DPRAM_Wr_Be;
    case (state_q)
      IDLE: begin
        mem_we = wr_ok;
        if (DPRAM_Clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(MEM_SIZE - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything, including a pending array write.
    if (DPRAM_Reset_InHigh) mem_we = 1'b0;
  end

  // Read word; with WR_FIRST the written lanes of a same-address write are
  // forwarded so the reader sees the byte-merged new word.
  always_comb begin
    rd_word = rd_in_range ? mem[DPRAM_Rd_Address] : '0;
    if (WR_FIRST != 0 && wr_ok && DPRAM_Wr_Address == DPRAM_Rd_Address) begin
      for (int b = 0; b < NB; b++)
        if (DPRAM_Wr_Be[b]) rd_word[8*b +: 8] = DPRAM_Wr_Data[8*b +: 8];
    end
  end

  always_comb begin
    rd_d      = rd_ok ? rd_word : rd_q;
    vld_d     = rd_ok;
    out_d     = vld_q ? rd_q : out_q;
    out_vld_d = vld_q;
  end

  always_ff @(posedge DPRAM_Clk) begin
    if (DPRAM_Reset_InHigh) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      rd_q      <= '0;
      vld_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      rd_q      <= rd_d;
      vld_q     <= vld_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Array storage has no reset; a reset mid-clear leaves it partially zeroed.
  always_ff @(posedge DPRAM_Clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign DPRAM_Rd_Data  = DPRAM_Oe ? ((OUT_REG != 0) ? out_q : rd_q) : '0;
  assign DPRAM_Rd_Valid = (OUT_REG != 0) ? out_vld_q : vld_q;
  assign DPRAM_Busy     = busy_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboarded bench for dual_port_ram: a word-array reference model predicts
// each accepted read; a negedge monitor pops predictions on Rd_Valid.
module tb_dual_port_ram #(
  parameter int OREG = 0,
  parameter int WRF  = 0
);
  localparam int DW = 32;
  localparam int MS = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    be = 4'h0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] ra = '0;
  logic          oe = 1'b1;
  logic          clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;

  dual_port_ram #(
    .DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW), .OUT_REG(OREG), .WR_FIRST(WRF)
  ) dut (
    .DPRAM_Clk(clk), .DPRAM_Reset_InHigh(rst),
    .DPRAM_Wr_En(wr_en), .DPRAM_Wr_Be(be), .DPRAM_Wr_Address(wa), .DPRAM_Wr_Data(wd),
    .DPRAM_Rd_En(rd_en), .DPRAM_Rd_Address(ra), .DPRAM_Oe(oe), .DPRAM_Clear(clr),
    .DPRAM_Rd_Data(rd_data), .DPRAM_Rd_Valid(rd_valid), .DPRAM_Busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_m [MS];
  int            busy_left = 0;
  int            cyc = 0;
  logic [DW-1:0] last_exp = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs held across it.
  task automatic model_edge();
    logic [DW-1:0] e;
    cyc++;
    if (rst) begin
      busy_left = 0;
      q.delete();
      last_exp = '0;
      return;
    end
    if (rd_en && busy_left == 0) begin
      e = (int'(ra) < MS) ? mem_m[ra] : '0;
      if (WRF != 0 && wr_en && wa == ra)
        for (int b = 0; b < 4; b++) if (be[b]) e[8*b +: 8] = wd[8*b +: 8];
      q.push_back('{e, cyc + OREG});
    end
    if (wr_en && busy_left == 0 && int'(wa) < MS)
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
    if (busy_left > 0) begin
      mem_m[MS - busy_left] = '0;
      busy_left--;
    end else if (clr) begin
      busy_left = MS;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; rd_en = 0; clr = 0; be = 4'h0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] m);
    wr_en = 1; wa = AW'(a); wd = d; be = m;
    tick();
    wr_en = 0;
  endtask

  task automatic rd(input int a);
    rd_en = 1; ra = AW'(a);
    tick();
    rd_en = 0;
  endtask

  task automatic fill();
    for (int a = 0; a < MS; a++) wr(a, $urandom, 4'hF);
  endtask

  task automatic read_all();
    rd_en = 1;
    for (int a = 0; a < MS; a++) begin
      ra = AW'(a);
      tick();
    end
    rd_en = 0;
    repeat (3) tick();
  endtask

  // Monitor: busy tracking, valid/latency against the queue, held read data.
  initial forever begin
    @(negedge clk);
    chk("busy", {31'b0, busy}, {31'b0, busy_left > 0});
    if (rd_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", {31'b0, rd_valid}, 32'd0);
      end else begin
        exp_t it;
        it = q.pop_front();
        chk("valid_latency", cyc, it.due);
        last_exp = it.data;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("missing_valid", {31'b0, rd_valid}, 32'd1);
      void'(q.pop_front());
    end
    chk("rd_data", rd_data, oe ? last_exp : '0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    repeat (2) tick();
    rst = 0;
    chk("reset_rd_data", rd_data, '0);
    chk("reset_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    fill();

    // Byte-lane merge.
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'h5);
    rd(3);
    repeat (OREG) tick();
    chk("merge_data", rd_data, 32'hAA22CC44);
    chk("merge_valid", {31'b0, rd_valid}, 32'd1);
    tick();

    // Same-address collision.
    wr(5, 32'h0, 4'hF);
    wr_en = 1; wa = 5; wd = 32'hFFFFFFFF; be = 4'hF;
    rd_en = 1; ra = 5;
    tick();
    idle_in();
    repeat (OREG) tick();
    chk("collision", rd_data, (WRF != 0) ? 32'hFFFFFFFF : 32'h0);
    tick();

    // Output-enable gating without a new read.
    wr(2, 32'h12345678, 4'hF);
    oe = 0;
    rd(2);
    repeat (OREG) tick();
    chk("oe_low_data", rd_data, '0);
    chk("oe_low_valid", {31'b0, rd_valid}, 32'd1);
    oe = 1;
    #1;
    chk("oe_high_data", rd_data, 32'h12345678);
    repeat (2) tick();

    // Full clear with traffic presented during Busy.
    fill();
    clr = 1;
    tick();
    clr = 0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(busy);
      wr_en = 1; wa = AW'($urandom); wd = $urandom; be = 4'hF;
      rd_en = (i < 16); ra = AW'($urandom);
      tick();
    end
    idle_in();
    chk("clear_busy_cycles", busy_cnt, 16);
    read_all();

    // Reset on the 8th Busy cycle aborts the sweep.
    fill();
    clr = 1;
    tick();
    clr = 0;
    repeat (7) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rd_data", rd_data, '0);
    read_all();

    // Random traffic, with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      wa    = AW'($urandom);
      wd    = $urandom;
      rd_en = 1'($urandom_range(0, 1));
      ra    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      oe    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 119) == 0);
      tick();
    end
    idle_in();
    rst = 0;
    oe = 1;
    repeat (4) tick();
    read_all();

    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
